// File: rtl/axil_initiator.sv
// AXI-Lite initiator: turns a val/rdy request into one AXI-Lite read or write
// at a time and returns the read data and response code on a val/rdy port.
module axil_initiator #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [3:0]        req_strb,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              resp_wr,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_code,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [1:0]        rresp,
  input  logic [31:0]       rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q;
  logic [3:0] strb_q;
  logic aw_done, w_done;
  logic aw_fin, w_fin;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign req_rdy = (state == IDLE);
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = data_q;
  assign wstrb   = strb_q;

  // A channel counts as done once its handshake happened, either earlier or now.
  always_comb begin
    aw_fin = aw_done | (awvalid & awready);
    w_fin  = w_done | (wvalid & wready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      resp_val  <= 1'b0;
      resp_wr   <= 1'b0;
      resp_data <= '0;
      resp_code <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            strb_q  <= req_strb;
            resp_wr <= req_wr;
            if (req_wr) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            state  <= WR_RESP;
            bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            resp_data <= '0;
            resp_code <= bresp;
            resp_val  <= 1'b1;
            state     <= RESP;
            wr_count  <= sat_inc(wr_count);
            if (bresp != 2'b00) err_count <= sat_inc(err_count);
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            resp_data <= rdata;
            resp_code <= rresp;
            resp_val  <= 1'b1;
            state     <= RESP;
            rd_count  <= sat_inc(rd_count);
            if (rresp != 2'b00) err_count <= sat_inc(err_count);
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_initiator.sv
// Directed bench for axil_initiator: a configurable-latency AXI-Lite responder
// plus a response scoreboard; counters run with CNT_W=2 to reach saturation.
module tb_axil_initiator;

  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val, req_rdy, req_wr;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb;
  logic        resp_val, resp_rdy, resp_wr;
  logic [31:0] resp_data;
  logic [1:0]  resp_code;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [1:0]  wr_count, rd_count, err_count;

  int total = 0;
  int bad = 0;

  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  int aw_cnt, w_cnt, ar_cnt, b_dly, r_dly;
  logic aw_got, w_got, ar_got;
  int b_hs = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;
  exp_t sb[$];
  int exp_wr = 0, exp_rd = 0, exp_err = 0;

  always #5 clk = ~clk;

  axil_initiator #(.ADDR_W(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_wr(resp_wr),
    .resp_data(resp_data), .resp_code(resp_code),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  // Responder: each ready rises after its valid has waited the configured cycles.
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid && (ar_cnt >= ar_wait);
  assign bresp   = bresp_cfg;
  assign rresp   = rresp_cfg;
  assign rdata   = rdata_cfg;

  always @(posedge clk) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_dly <= 0; r_dly <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      if (awvalid && awready) begin aw_cnt <= 0; aw_got <= 1'b1; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_cnt <= 0; w_got <= 1'b1; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (arvalid && arready) begin ar_cnt <= 0; ar_got <= 1'b1; end
      else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_hs <= b_hs + 1;
      end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        if (b_dly >= b_wait) begin bvalid <= 1'b1; b_dly <= 0; end
        else b_dly <= b_dly + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; ar_got <= 1'b0;
      end else if (!rvalid && (ar_got || (arvalid && arready))) begin
        if (r_dly >= r_wait) begin rvalid <= 1'b1; r_dly <= 0; end
        else r_dly <= r_dly + 1;
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called on a negedge; returns on the negedge of the cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    exp_t e;
    int n;
    e.wr = wr;
    e.data = wr ? 32'h0 : rdata_cfg;
    e.code = wr ? bresp_cfg : rresp_cfg;
    sb.push_back(e);
    req_wr = wr; req_addr = addr; req_data = data; req_strb = strb; req_val = 1'b1;
    n = 0;
    while (!req_rdy && n < 50) begin @(negedge clk); n++; end
    checkOutput("req_rdy_wait", {31'b0, req_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic collectResponse();
    exp_t e;
    int n;
    n = 0;
    while (!resp_val && n < 100) begin @(negedge clk); n++; end
    checkOutput("resp_val_wait", {31'b0, resp_val}, 32'd1);
    checkOutput("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("resp_wr", {31'b0, resp_wr}, {31'b0, e.wr});
      checkOutput("resp_data", resp_data, e.data);
      checkOutput("resp_code", {30'b0, resp_code}, {30'b0, e.code});
      if (e.wr) exp_wr = sat(exp_wr); else exp_rd = sat(exp_rd);
      if (e.code != 2'b00) exp_err = sat(exp_err);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    checkOutput("resp_val_drop", {31'b0, resp_val}, 32'd0);
    checkOutput("wr_count", {30'b0, wr_count}, exp_wr);
    checkOutput("rd_count", {30'b0, rd_count}, exp_rd);
    checkOutput("err_count", {30'b0, err_count}, exp_err);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req_rdy"}, {31'b0, req_rdy}, 32'd1);
    checkOutput({tag, "_valids"}, {27'b0, awvalid, wvalid, arvalid, resp_val, 1'b0}, 32'd0);
    checkOutput({tag, "_readies"}, {30'b0, bready, rready}, 32'd0);
    checkOutput({tag, "_counts"}, {26'b0, wr_count, rd_count, err_count}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs0;
    reset = 1'b1; req_val = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    req_strb = '0; resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 32'h0000_0500, 32'hDEAD_BEEF, 4'hF);
    checkOutput("t1_aw_w_valid", {30'b0, awvalid, wvalid}, 32'd3);
    checkOutput("t1_awaddr", awaddr, 32'h0000_0500);
    checkOutput("t1_wdata", wdata, 32'hDEAD_BEEF);
    checkOutput("t1_wstrb", {28'b0, wstrb}, 32'hF);
    checkOutput("t1_req_rdy_low", {31'b0, req_rdy}, 32'd0);
    @(negedge clk);
    checkOutput("t1_bready", {31'b0, bready}, 32'd1);
    checkOutput("t1_aw_w_dropped", {30'b0, awvalid, wvalid}, 32'd0);
    @(negedge clk);
    checkOutput("t1_resp_val_c3", {31'b0, resp_val}, 32'd1);
    collectResponse();

    $display("[TB] read with 5 wait cycles on rvalid");
    r_wait = 5; rdata_cfg = 32'h0000_CAFE;
    applyStimulus(1'b0, 32'h0000_0504, 32'h0, 4'h0);
    checkOutput("t2_arvalid", {31'b0, arvalid}, 32'd1);
    checkOutput("t2_araddr", araddr, 32'h0000_0504);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_rready_held", {29'b0, rready, rvalid, resp_val}, 32'd4);
    end
    collectResponse();
    r_wait = 0;

    $display("[TB] write with wready before awready");
    aw_wait = 3; w_wait = 1;
    hs0 = b_hs;
    applyStimulus(1'b1, 32'h0000_0510, 32'h1234_5678, 4'h3);
    checkOutput("t3_c1_valids", {30'b0, awvalid, wvalid}, 32'd3);
    @(negedge clk);
    checkOutput("t3_c2_valids", {30'b0, awvalid, wvalid}, 32'd3);
    @(negedge clk);
    checkOutput("t3_c3_valids", {30'b0, awvalid, wvalid}, 32'd2);
    @(negedge clk);
    checkOutput("t3_c4_valids", {29'b0, awvalid, wvalid, bready}, 32'd4);
    @(negedge clk);
    checkOutput("t3_c5_bready", {29'b0, awvalid, wvalid, bready}, 32'd1);
    collectResponse();
    repeat (3) @(negedge clk);
    checkOutput("t3_one_b_hs", b_hs, hs0 + 1);
    aw_wait = 0; w_wait = 0;

    $display("[TB] read with error response");
    rresp_cfg = 2'b10; rdata_cfg = 32'hA5A5_0001;
    applyStimulus(1'b0, 32'h0000_0600, 32'h0, 4'h0);
    collectResponse();
    rresp_cfg = 2'b00;

    $display("[TB] response backpressure");
    applyStimulus(1'b1, 32'h0000_0700, 32'hFEED_F00D, 4'hC);
    while (!resp_val) @(negedge clk);
    rdata_cfg = 32'h0000_1234;
    req_wr = 1'b0; req_addr = 32'h0000_0508; req_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t5_hold_val", {29'b0, resp_val, req_rdy, arvalid}, 32'd4);
      checkOutput("t5_hold_fields", {resp_data[29:0], resp_code}, {sb[0].data[29:0], sb[0].code});
      checkOutput("t5_hold_wr", {31'b0, resp_wr}, {31'b0, sb[0].wr});
      @(negedge clk);
    end
    collectResponse();
    checkOutput("t5_after_hs", {30'b0, req_rdy, arvalid}, 32'd2);
    applyStimulus(1'b0, 32'h0000_0508, 32'h0, 4'h0);
    collectResponse();

    $display("[TB] reset during WR_RESP, then saturate wr_count");
    b_wait = 20;
    applyStimulus(1'b1, 32'h0000_0800, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    checkOutput("t6_in_wr_resp", {31'b0, bready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkIdle("t6_reset");
    checkOutput("t6_bvalid_resp", {31'b0, bvalid}, 32'd0);
    reset = 1'b0;
    sb.delete();
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    b_wait = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0000_0900 + 32'(i * 4), 32'h1111_0000 + 32'(i), (i == 2) ? 4'h0 : 4'hF);
      checkOutput("t6_wstrb", {28'b0, wstrb}, (i == 2) ? 32'h0 : 32'hF);
      collectResponse();
    end
    checkOutput("t6_wr_sat", {30'b0, wr_count}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
